// File: rtl/disp_row_scheduler.sv
// disp_row_scheduler
// Steps the compute_max_disp engine across every legal column of one stereo
// row. For each column it restarts the engine, waits for its done flag (or a
// watchdog limit) and streams the winning disparity on a valid/ready port.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   row_valid   row bands loaded and stable (sampled only while idle)
//   row_ready   scheduler idle, a row can be accepted
//   eng_rst     synchronous active-high engine reset, low only while searching
//   eng_col     column index the engine is searching
//   eng_done    engine done flag
//   eng_disp    engine winning disparity
//   disp_valid  result available
//   disp_ready  downstream accepts the result
//   disp_data   disparity value (0 when the search timed out)
//   disp_col    column of disp_data
//   disp_last   disp_data belongs to the last column of the row
//   row_done    one-cycle pulse on the transfer of the last column
//   err         sticky watchdog flag, cleared only by reset
module disp_row_scheduler #(
    parameter int IMG_W        = 128,
    parameter int WIN          = 15,
    parameter int MAX_DISP     = 64,
    parameter int DISP_THREADS = 16,
    parameter int TIMEOUT      = MAX_DISP / DISP_THREADS + 4,
    localparam int NUM_COLS    = IMG_W - WIN - MAX_DISP + 2,
    localparam int COL_BITS    = $clog2(IMG_W),
    localparam int DISP_BITS   = $clog2(MAX_DISP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 row_valid,
    output logic                 row_ready,
    output logic                 eng_rst,
    output logic [COL_BITS-1:0]  eng_col,
    input  logic                 eng_done,
    input  logic [DISP_BITS-1:0] eng_disp,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [DISP_BITS-1:0] disp_data,
    output logic [COL_BITS-1:0]  disp_col,
    output logic                 disp_last,
    output logic                 row_done,
    output logic                 err
);

    localparam int WAIT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(NUM_COLS - 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);

    if (NUM_COLS < 1) begin : g_bad_geometry
        $error("disp_row_scheduler: IMG_W - WIN - MAX_DISP + 2 must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t               state;
    logic [COL_BITS-1:0]  col;
    logic [WAIT_BITS-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row_ready  <= 1'b1;
            eng_rst    <= 1'b1;
            col        <= '0;
            wait_cnt   <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            disp_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (row_valid) begin
                        state     <= S_START;
                        row_ready <= 1'b0;
                        col       <= '0;
                    end
                end

                S_START: begin
                    state    <= S_WAIT;
                    eng_rst  <= 1'b0;
                    wait_cnt <= '0;
                end

                S_WAIT: begin
                    // eng_done is tested first so a result arriving on the
                    // final allowed cycle is kept rather than flagged.
                    if (eng_done) begin
                        state      <= S_OUT;
                        eng_rst    <= 1'b1;
                        disp_valid <= 1'b1;
                        disp_data  <= eng_disp;
                        disp_last  <= (col == COL_LAST);
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= S_OUT;
                        eng_rst    <= 1'b1;
                        disp_valid <= 1'b1;
                        disp_data  <= '0;
                        disp_last  <= (col == COL_LAST);
                        err        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_OUT: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        disp_last  <= 1'b0;
                        if (col == COL_LAST) begin
                            state     <= S_IDLE;
                            row_ready <= 1'b1;
                        end else begin
                            state <= S_START;
                            col   <= col + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign eng_col  = col;
    assign disp_col = col;

    // Decoded from the handshake so the pulse lands in the transfer cycle
    // itself, leaving the scheduler idle on the very next cycle.
    assign row_done = disp_valid & disp_ready & disp_last;

endmodule

// File: tb/tb_disp_row_scheduler.sv
module tb_disp_row_scheduler;

    localparam int IMG_W        = 128;
    localparam int WIN          = 15;
    localparam int MAX_DISP     = 64;
    localparam int DISP_THREADS = 16;
    localparam int G            = MAX_DISP / DISP_THREADS;
    localparam int TIMEOUT      = G + 4;
    localparam int NUM_COLS     = IMG_W - WIN - MAX_DISP + 2;
    localparam int COL_BITS     = 7;
    localparam int DISP_BITS    = 6;
    localparam int HANG         = 1000;
    localparam int BUDGET       = NUM_COLS * (TIMEOUT + 10) + 50;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic row_valid = 1'b0;
    logic disp_ready = 1'b0;
    logic row_ready, eng_rst, eng_done, disp_valid, disp_last, row_done, err;
    logic [COL_BITS-1:0]  eng_col, disp_col;
    logic [DISP_BITS-1:0] eng_disp, disp_data;

    disp_row_scheduler #(
        .IMG_W(IMG_W),
        .WIN(WIN),
        .MAX_DISP(MAX_DISP),
        .DISP_THREADS(DISP_THREADS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .eng_rst(eng_rst),
        .eng_col(eng_col),
        .eng_done(eng_done),
        .eng_disp(eng_disp),
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .disp_data(disp_data),
        .disp_col(disp_col),
        .disp_last(disp_last),
        .row_done(row_done),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-column scenario tables: engine latency in WAIT cycles (HANG = never),
    // engine result, and how many OUT cycles downstream holds disp_ready low.
    int                   lat   [128];
    logic [DISP_BITS-1:0] val   [128];
    int                   stall [128];

    // Engine model: counts cycles spent out of reset, done on the lat-th one.
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_rst !== 1'b0) eng_cnt <= 0;
        else                  eng_cnt <= eng_cnt + 1;
    end
    assign eng_done = (eng_rst === 1'b0) && (eng_cnt + 1 == lat[eng_col]);
    assign eng_disp = val[eng_col];

    // Reference model of one row, in cycles counted from the accept edge.
    bit                   err_sticky = 1'b0;
    int                   exp_first [NUM_COLS];
    int                   exp_xfer  [NUM_COLS];
    logic [DISP_BITS-1:0] exp_data  [NUM_COLS];
    logic                 exp_err   [NUM_COLS];
    int                   exp_samples;

    function automatic void model_row();
        int  t;
        bit  e;
        t = 0;
        e = err_sticky;
        exp_samples = 0;
        for (int c = 0; c < NUM_COLS; c++) begin
            int k;
            k = (lat[c] <= TIMEOUT) ? lat[c] : TIMEOUT;
            exp_data[c]  = (lat[c] <= TIMEOUT) ? val[c] : '0;
            if (lat[c] > TIMEOUT) e = 1'b1;
            exp_err[c]   = e;
            exp_first[c] = t + 1 + k + 1;
            exp_xfer[c]  = exp_first[c] + stall[c];
            exp_samples += stall[c] + 1;
            t = exp_xfer[c];
        end
    endfunction

    function automatic int col_at(input int cyc);
        for (int c = 0; c < NUM_COLS; c++)
            if (cyc >= exp_first[c] && cyc <= exp_xfer[c]) return c;
        return -1;
    endfunction

    typedef struct {
        int                   cyc;
        logic [COL_BITS-1:0]  col;
        logic [DISP_BITS-1:0] data;
        logic                 last;
        logic [COL_BITS-1:0]  ecol;
        logic                 erst;
        logic                 err;
    } smp_t;

    smp_t obs[$];
    logic acc_ready;
    int   rowdone_cyc;

    // Offers one row, plays downstream per the stall table and records every
    // cycle with disp_valid high until row_done (bounded by BUDGET).
    task automatic run_row(input int pulse_col);
        int   out_cnt;
        bit   pulsed;
        bit   done;
        smp_t s;
        obs.delete();
        rowdone_cyc = -1;
        out_cnt = 0;
        pulsed = 1'b0;
        done = 1'b0;
        @(negedge clk);
        acc_ready  = row_ready;
        row_valid  = 1'b1;
        disp_ready = 1'b0;
        @(posedge clk);
        #1 row_valid = 1'b0;
        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            @(negedge clk);
            row_valid = 1'b0;
            if (disp_valid === 1'b1) begin
                disp_ready = (out_cnt >= stall[disp_col]);
                out_cnt++;
                if (!pulsed && disp_col == pulse_col) begin
                    row_valid = 1'b1;
                    pulsed = 1'b1;
                end
            end else begin
                disp_ready = 1'b0;
                out_cnt = 0;
            end
            #1;
            if (disp_valid === 1'b1) begin
                s.cyc = cyc; s.col = disp_col; s.data = disp_data; s.last = disp_last;
                s.ecol = eng_col; s.erst = eng_rst; s.err = err;
                obs.push_back(s);
            end
            if (row_done === 1'b1) begin
                rowdone_cyc = cyc;
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({row_ready, eng_rst, disp_valid, disp_last, row_done, err} !== 6'b110000) begin
            n_bad++;
            $display("FAIL reset_flags: got ready/eng_rst/valid/last/row_done/err=%b want 110000",
                     {row_ready, eng_rst, disp_valid, disp_last, row_done, err});
        end
        n_cmp++;
        if (eng_col !== '0 || disp_col !== '0 || disp_data !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got eng_col=%0d disp_col=%0d disp_data=%0d want 0/0/0",
                     eng_col, disp_col, disp_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (row_ready !== 1'b1 || eng_rst !== 1'b1 || disp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got ready=%b eng_rst=%b valid=%b want 1/1/0",
                     row_ready, eng_rst, disp_valid);
        end
    endtask

    task automatic test_nominal();
        int c;
        for (int i = 0; i < NUM_COLS; i++) begin
            lat[i] = G; val[i] = DISP_BITS'(i % MAX_DISP); stall[i] = 0;
        end
        model_row();
        run_row(-1);
        n_cmp++;
        if (acc_ready !== 1'b1) begin
            n_bad++; $display("FAIL nominal_accept: row_ready=%b want 1", acc_ready);
        end
        foreach (obs[i]) begin
            c = col_at(obs[i].cyc);
            n_cmp++;
            if (c < 0) begin
                n_bad++; $display("FAIL nominal_valid_timing: disp_valid at cycle %0d, col %0d; want no result", obs[i].cyc, obs[i].col);
            end else if (obs[i].col !== COL_BITS'(c) || obs[i].ecol !== COL_BITS'(c) || obs[i].data !== exp_data[c]
                         || obs[i].last !== (c == NUM_COLS - 1) || obs[i].erst !== 1'b1 || obs[i].err !== exp_err[c]) begin
                n_bad++;
                $display("FAIL nominal_result cyc=%0d: got col=%0d eng_col=%0d data=%0d last=%b eng_rst=%b err=%b want col=%0d data=%0d last=%b eng_rst=1 err=%b",
                         obs[i].cyc, obs[i].col, obs[i].ecol, obs[i].data, obs[i].last, obs[i].erst, obs[i].err,
                         c, exp_data[c], (c == NUM_COLS - 1), exp_err[c]);
            end
        end
        n_cmp++;
        if (obs.size() != exp_samples) begin
            n_bad++; $display("FAIL nominal_count: got %0d valid cycles want %0d", obs.size(), exp_samples);
        end
        n_cmp++;
        if (rowdone_cyc != NUM_COLS * (2 + G)) begin
            n_bad++; $display("FAIL nominal_row_done: got cycle %0d want %0d", rowdone_cyc, NUM_COLS * (2 + G));
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL nominal_err: got %b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        for (int i = 0; i < NUM_COLS; i++) begin
            lat[i] = $urandom_range(1, TIMEOUT); val[i] = DISP_BITS'($urandom); stall[i] = 0;
        end
        model_row();
        for (int r = 0; r < 2; r++) begin
            run_row((r == 0) ? 10 : -1);
            n_cmp++;
            if (acc_ready !== 1'b1) begin
                n_bad++; $display("FAIL b2b_accept row%0d: row_ready=%b want 1", r, acc_ready);
            end
            foreach (obs[i]) begin
                c = col_at(obs[i].cyc);
                n_cmp++;
                if (c < 0) begin
                    n_bad++; $display("FAIL b2b_valid_timing row%0d: disp_valid at cycle %0d col %0d; want no result", r, obs[i].cyc, obs[i].col);
                end else if (obs[i].col !== COL_BITS'(c) || obs[i].ecol !== COL_BITS'(c) || obs[i].data !== exp_data[c]
                             || obs[i].last !== (c == NUM_COLS - 1) || obs[i].erst !== 1'b1 || obs[i].err !== exp_err[c]) begin
                    n_bad++;
                    $display("FAIL b2b_result row%0d cyc=%0d: got col=%0d eng_col=%0d data=%0d last=%b eng_rst=%b err=%b want col=%0d data=%0d last=%b err=%b",
                             r, obs[i].cyc, obs[i].col, obs[i].ecol, obs[i].data, obs[i].last, obs[i].erst, obs[i].err,
                             c, exp_data[c], (c == NUM_COLS - 1), exp_err[c]);
                end
            end
            n_cmp++;
            if (obs.size() != exp_samples || rowdone_cyc != exp_xfer[NUM_COLS - 1]) begin
                n_bad++; $display("FAIL b2b_row row%0d: got %0d valid cycles, row_done at %0d want %0d, %0d",
                                  r, obs.size(), rowdone_cyc, exp_samples, exp_xfer[NUM_COLS - 1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        int n3;
        for (int i = 0; i < NUM_COLS; i++) begin
            lat[i] = $urandom_range(1, TIMEOUT); val[i] = DISP_BITS'($urandom); stall[i] = $urandom_range(0, 2);
        end
        stall[3] = 5;
        model_row();
        run_row(-1);
        n3 = 0;
        foreach (obs[i]) begin
            c = col_at(obs[i].cyc);
            if (obs[i].col == 3) n3++;
            n_cmp++;
            if (c < 0) begin
                n_bad++; $display("FAIL bp_valid_timing: disp_valid at cycle %0d col %0d; want no result", obs[i].cyc, obs[i].col);
            end else if (obs[i].col !== COL_BITS'(c) || obs[i].ecol !== COL_BITS'(c) || obs[i].data !== exp_data[c]
                         || obs[i].last !== (c == NUM_COLS - 1) || obs[i].erst !== 1'b1 || obs[i].err !== exp_err[c]) begin
                n_bad++;
                $display("FAIL bp_hold cyc=%0d: got col=%0d eng_col=%0d data=%0d last=%b eng_rst=%b err=%b want col=%0d data=%0d last=%b err=%b",
                         obs[i].cyc, obs[i].col, obs[i].ecol, obs[i].data, obs[i].last, obs[i].erst, obs[i].err,
                         c, exp_data[c], (c == NUM_COLS - 1), exp_err[c]);
            end
        end
        n_cmp++;
        if (n3 != 6) begin
            n_bad++; $display("FAIL bp_col3_cycles: got %0d valid cycles on column 3 want 6", n3);
        end
        n_cmp++;
        if (obs.size() != exp_samples || rowdone_cyc != exp_xfer[NUM_COLS - 1]) begin
            n_bad++; $display("FAIL bp_row: got %0d valid cycles, row_done at %0d want %0d, %0d",
                              obs.size(), rowdone_cyc, exp_samples, exp_xfer[NUM_COLS - 1]);
        end
    endtask

    task automatic test_done_at_limit();
        int c;
        for (int i = 0; i < NUM_COLS; i++) begin
            lat[i] = (i % 3 == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT - 1);
            val[i] = DISP_BITS'($urandom_range(1, MAX_DISP - 1));
            stall[i] = 0;
        end
        model_row();
        run_row(-1);
        foreach (obs[i]) begin
            c = col_at(obs[i].cyc);
            n_cmp++;
            if (c < 0) begin
                n_bad++; $display("FAIL limit_valid_timing: disp_valid at cycle %0d col %0d; want no result", obs[i].cyc, obs[i].col);
            end else if (obs[i].col !== COL_BITS'(c) || obs[i].data !== exp_data[c] || obs[i].err !== exp_err[c]) begin
                n_bad++;
                $display("FAIL limit_result cyc=%0d: got col=%0d data=%0d err=%b want col=%0d data=%0d err=%b",
                         obs[i].cyc, obs[i].col, obs[i].data, obs[i].err, c, exp_data[c], exp_err[c]);
            end
        end
        n_cmp++;
        if (obs.size() != exp_samples || rowdone_cyc != exp_xfer[NUM_COLS - 1] || err !== 1'b0) begin
            n_bad++; $display("FAIL limit_row: got %0d valid cycles, row_done at %0d, err=%b want %0d, %0d, err=0",
                              obs.size(), rowdone_cyc, err, exp_samples, exp_xfer[NUM_COLS - 1]);
        end
    endtask

    task automatic test_hang();
        int c;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                lat[i] = $urandom_range(1, TIMEOUT); val[i] = DISP_BITS'($urandom_range(1, MAX_DISP - 1));
                stall[i] = $urandom_range(0, 1);
            end
            if (r == 0) lat[7] = HANG;
            model_row();
            run_row(-1);
            foreach (obs[i]) begin
                c = col_at(obs[i].cyc);
                n_cmp++;
                if (c < 0) begin
                    n_bad++; $display("FAIL hang_valid_timing row%0d: disp_valid at cycle %0d col %0d; want no result", r, obs[i].cyc, obs[i].col);
                end else if (obs[i].col !== COL_BITS'(c) || obs[i].ecol !== COL_BITS'(c) || obs[i].data !== exp_data[c]
                             || obs[i].erst !== 1'b1 || obs[i].err !== exp_err[c]) begin
                    n_bad++;
                    $display("FAIL hang_result row%0d cyc=%0d: got col=%0d eng_col=%0d data=%0d eng_rst=%b err=%b want col=%0d data=%0d err=%b",
                             r, obs[i].cyc, obs[i].col, obs[i].ecol, obs[i].data, obs[i].erst, obs[i].err,
                             c, exp_data[c], exp_err[c]);
                end
            end
            n_cmp++;
            if (obs.size() != exp_samples || rowdone_cyc != exp_xfer[NUM_COLS - 1] || err !== 1'b1) begin
                n_bad++; $display("FAIL hang_row row%0d: got %0d valid cycles, row_done at %0d, err=%b want %0d, %0d, err=1",
                                  r, obs.size(), rowdone_cyc, err, exp_samples, exp_xfer[NUM_COLS - 1]);
            end
            err_sticky = exp_err[NUM_COLS - 1];
        end
    endtask

    task automatic test_reset_mid_row();
        bit found;
        int c;
        for (int i = 0; i < NUM_COLS; i++) begin
            lat[i] = G; val[i] = DISP_BITS'(i + 1); stall[i] = 0;
        end
        lat[5] = HANG;
        @(negedge clk);
        row_valid = 1'b1;
        @(posedge clk);
        #1 row_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge clk);
            disp_ready = disp_valid;
            if (eng_col == 20 && eng_rst === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found || err !== 1'b1) begin
            n_bad++; $display("FAIL midrow_reach: reached WAIT of column 20=%b err=%b want 1/1", found, err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({row_ready, eng_rst, disp_valid, disp_last, row_done, err} !== 6'b110000) begin
            n_bad++;
            $display("FAIL midrow_reset_flags: got ready/eng_rst/valid/last/row_done/err=%b want 110000",
                     {row_ready, eng_rst, disp_valid, disp_last, row_done, err});
        end
        n_cmp++;
        if (eng_col !== '0 || disp_col !== '0 || disp_data !== '0) begin
            n_bad++;
            $display("FAIL midrow_reset_values: got eng_col=%0d disp_col=%0d disp_data=%0d want 0/0/0",
                     eng_col, disp_col, disp_data);
        end
        disp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        err_sticky = 1'b0;
        lat[5] = G;
        model_row();
        run_row(-1);
        n_cmp++;
        if (obs.size() == 0 || obs[0].col !== '0 || obs[0].ecol !== '0 || obs[0].cyc != exp_first[0]) begin
            n_bad++;
            $display("FAIL midrow_restart: first result col=%0d eng_col=%0d cycle=%0d want col 0 at cycle %0d",
                     (obs.size() > 0) ? int'(obs[0].col) : -1, (obs.size() > 0) ? int'(obs[0].ecol) : -1,
                     (obs.size() > 0) ? obs[0].cyc : -1, exp_first[0]);
        end
        foreach (obs[i]) begin
            c = col_at(obs[i].cyc);
            n_cmp++;
            if (c < 0) begin
                n_bad++; $display("FAIL midrow_valid_timing: disp_valid at cycle %0d col %0d; want no result", obs[i].cyc, obs[i].col);
            end else if (obs[i].col !== COL_BITS'(c) || obs[i].data !== exp_data[c] || obs[i].err !== 1'b0) begin
                n_bad++;
                $display("FAIL midrow_result cyc=%0d: got col=%0d data=%0d err=%b want col=%0d data=%0d err=0",
                         obs[i].cyc, obs[i].col, obs[i].data, obs[i].err, c, exp_data[c]);
            end
        end
        n_cmp++;
        if (rowdone_cyc != exp_xfer[NUM_COLS - 1]) begin
            n_bad++; $display("FAIL midrow_row_done: got cycle %0d want %0d", rowdone_cyc, exp_xfer[NUM_COLS - 1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary want summary");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            lat[i] = G; val[i] = '0; stall[i] = 0;
        end
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_done_at_limit();
        test_hang();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
